// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction class encodings, control bundle,
// and instruction field offsets.
package decode_pkg;

  localparam int unsigned OPC_W  = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned RD_LSB = OPC_W;

  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_LOAD    = 2'b10,
    CLS_MEM     = 2'b11
  } op_class_e;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic branch;
    logic setflags;
    logic use_imm;
  } ctrl_t;

  // Field layout from the LSB up: opcode, rd, ra, rb, use_imm, ..., imm at the top.
  function automatic int unsigned ra_lsb(input int unsigned aw);
    return OPC_W + aw;
  endfunction

  function automatic int unsigned rb_lsb(input int unsigned aw);
    return OPC_W + 2 * aw;
  endfunction

  function automatic int unsigned use_imm_bit(input int unsigned aw);
    return OPC_W + 3 * aw;
  endfunction

  function automatic int unsigned imm_lsb(input int unsigned ilen, input int unsigned immw);
    return ilen - immw;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opcode, input logic instr_use_imm);
    ctrl_t c;
    c = '0;
    case (op_class_e'(opcode[1:0]))
      CLS_ALU_REG: begin
        c.regwrite = 1'b1;
        c.setflags = 1'b1;
      end
      CLS_ALU_IMM: begin
        c.regwrite = 1'b1;
        c.setflags = 1'b1;
        c.use_imm  = 1'b1;
      end
      CLS_LOAD: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.use_imm  = 1'b1;
      end
      default: begin
        c.branch   = opcode[2];
        c.memwrite = ~opcode[2];
        c.use_imm  = 1'b1;
      end
    endcase
    c.use_imm = c.use_imm | instr_use_imm;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipelined_regfile.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one write port, register 0 hardwired to zero.
module decode_stage_pipelined_regfile #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a_c,
  output logic [XLEN-1:0] rdata_b_c
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = (raddr_a == '0) ? '0 :
                     (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
  assign rdata_b_c = (raddr_b == '0) ? '0 :
                     (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];

endmodule

// File: rtl/decode_stage_pipelined.sv
// Decode stage: field extraction, RAW scoreboard with stall, register read
// with writeback bypass, and a registered bundle toward execute.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ILEN  = 64,
  parameter int unsigned IMMW  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          instruction,
  input  logic                     wb_regwrite,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     wb_setflags,
  input  logic [FLAG_W-1:0]        wb_flags,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          operand_a,
  output logic [XLEN-1:0]          operand_b,
  output logic [XLEN-1:0]          store_data,
  output logic [OPC_W-1:0]         aluop,
  output logic [$clog2(NREGS)-1:0] write_addr,
  output logic                     regwrite,
  output logic                     memwrite,
  output logic                     memtoreg,
  output logic                     branch,
  output logic                     setflags,
  output logic [FLAG_W-1:0]        flags
);

  localparam int unsigned AW      = $clog2(NREGS);
  localparam int unsigned RA_LSB  = ra_lsb(AW);
  localparam int unsigned RB_LSB  = rb_lsb(AW);
  localparam int unsigned UI_BIT  = use_imm_bit(AW);
  localparam int unsigned IMM_LSB = imm_lsb(ILEN, IMMW);

  logic [OPC_W-1:0] opcode;
  logic [AW-1:0]    rd, ra, rb;
  logic [IMMW-1:0]  imm;
  logic [XLEN-1:0]  imm_sext;
  ctrl_t            ctrl;
  logic             uses_rb;

  logic [NREGS-1:1] pend;
  logic [NREGS-1:0] pend_full, clr_vec, set_vec, busy, pend_nxt_full;
  logic             hazard, accept;
  logic [XLEN-1:0]  rdata_a, rdata_b;
  logic             unused_bits;

  assign opcode   = instruction[OPC_W-1:0];
  assign rd       = instruction[RD_LSB +: AW];
  assign ra       = instruction[RA_LSB +: AW];
  assign rb       = instruction[RB_LSB +: AW];
  assign imm      = instruction[IMM_LSB +: IMMW];
  assign imm_sext = {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
  assign ctrl     = decode_ctrl(opcode, instruction[UI_BIT]);
  // Stores always need rb for store_data even though operand_b is the immediate.
  assign uses_rb  = ~ctrl.use_imm | ctrl.memwrite;

  // A writeback landing this cycle releases its register, so it no longer blocks.
  assign pend_full     = {pend, 1'b0};
  assign clr_vec       = wb_regwrite ? (NREGS'(1) << wb_addr) : '0;
  assign busy          = pend_full & ~clr_vec;
  assign hazard        = busy[ra] | (uses_rb & busy[rb]);
  assign in_ready      = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept        = in_valid & in_ready;
  assign set_vec       = (accept && ctrl.regwrite && (rd != '0)) ? (NREGS'(1) << rd) : '0;
  assign pend_nxt_full = busy | set_vec;
  assign unused_bits   = ^{instruction, pend_nxt_full[0]};

  decode_stage_pipelined_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_regwrite),
    .waddr     (wb_addr),
    .wdata     (wb_data),
    .raddr_a   (ra),
    .raddr_b   (rb),
    .rdata_a_c (rdata_a),
    .rdata_b_c (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) pend <= '0;
    else              pend <= pend_nxt_full[NREGS-1:1];
  end

  always_ff @(posedge clk) begin
    if (rst)              flags <= '0;
    else if (wb_setflags) flags <= wb_flags;
  end

  // Output bundle: loads on accept, holds while execute back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      operand_a  <= '0;
      operand_b  <= '0;
      store_data <= '0;
      aluop      <= '0;
      write_addr <= '0;
      regwrite   <= 1'b0;
      memwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      branch     <= 1'b0;
      setflags   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      operand_a  <= rdata_a;
      operand_b  <= ctrl.use_imm ? imm_sext : rdata_b;
      store_data <= rdata_b;
      aluop      <= opcode;
      write_addr <= rd;
      regwrite   <= ctrl.regwrite;
      memwrite   <= ctrl.memwrite;
      memtoreg   <= ctrl.memtoreg;
      branch     <= ctrl.branch;
      setflags   <= ctrl.setflags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: vector table plus directed hazard,
// back-pressure, flush and reset sequences, checked through an expected queue.
module tb_decode_stage_pipelined;

  localparam int unsigned XLEN = 64, NREGS = 32, ILEN = 64, IMMW = 32, AW = 5;
  localparam logic [4:0] RW = 5'b10000, MW = 5'b01000, MR = 5'b00100, BR = 5'b00010, SF = 5'b00001;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sd;
    logic [7:0]  op;
    logic [4:0]  wa;
    logic [4:0]  ctl;
  } bundle_t;

  typedef struct packed {
    logic [63:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    bundle_t     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, wb_regwrite, wb_setflags, flush, out_valid, out_ready;
  logic [ILEN-1:0] instruction;
  logic [AW-1:0]   wb_addr, write_addr;
  logic [XLEN-1:0] wb_data, operand_a, operand_b, store_data;
  logic [3:0]      wb_flags, flags;
  logic [7:0]      aluop;
  logic            regwrite, memwrite, memtoreg, branch, setflags;

  always #5 clk = ~clk;

  decode_stage_pipelined #(.XLEN(XLEN), .NREGS(NREGS), .ILEN(ILEN), .IMMW(IMMW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_setflags(wb_setflags), .wb_flags(wb_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a), .operand_b(operand_b),
    .store_data(store_data), .aluop(aluop), .write_addr(write_addr), .regwrite(regwrite),
    .memwrite(memwrite), .memtoreg(memtoreg), .branch(branch), .setflags(setflags), .flags(flags)
  );

  bundle_t q[$];
  bundle_t cur_exp;
  int      total = 0, bad = 0;
  logic    last_ready, last_accept;
  vec_t    vt[8];

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic ui, input logic [31:0] imm);
    return {imm, 8'h00, ui, rb, ra, rd, op};
  endfunction

  function automatic bundle_t bx(input logic [63:0] a, input logic [63:0] b, input logic [63:0] sd,
                                 input logic [7:0] op, input logic [4:0] wa, input logic [4:0] ctl);
    return {a, b, sd, op, wa, ctl};
  endfunction

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One cycle: sample just after the inputs settle, score any delivered bundle, then advance.
  task automatic tick();
    bundle_t got, want;
    #1;
    last_ready  = in_ready;
    last_accept = in_valid && in_ready;
    if (out_valid === 1'b1 && out_ready) begin
      got = bx(operand_a, operand_b, store_data, aluop, write_addr,
               {regwrite, memwrite, memtoreg, branch, setflags});
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bundle got=%h", got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL bundle got=%h want=%h", got, want);
        end
      end
    end
    if (last_accept) q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] instr, input bundle_t e, output int n);
    in_valid    = 1'b1;
    instruction = instr;
    cur_exp     = e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 20);
    in_valid = 1'b0;
    if (!last_accept) begin
      total++;
      bad++;
      $display("FAIL issue_timeout instr=%h got=not_accepted want=accepted", instr);
    end
  endtask

  initial begin
    int n;
    vt[0] = '{mk(8'h40, 5'd8,  5'd1, 5'd2, 1'b0, 32'h0),        1'b0, 5'd0,  64'h0,
              bx(64'h11, 64'h22, 64'h22, 8'h40, 5'd8, RW | SF)};
    vt[1] = '{mk(8'h81, 5'd9,  5'd2, 5'd4, 1'b0, 32'hFFFFFFFB), 1'b0, 5'd0,  64'h0,
              bx(64'h22, 64'hFFFFFFFFFFFFFFFB, 64'h44, 8'h81, 5'd9, RW | SF)};
    vt[2] = '{mk(8'hC2, 5'd10, 5'd4, 5'd0, 1'b0, 32'h10),       1'b0, 5'd0,  64'h0,
              bx(64'h44, 64'h10, 64'h0, 8'hC2, 5'd10, RW | MR)};
    vt[3] = '{mk(8'h13, 5'd21, 5'd1, 5'd2, 1'b0, 32'h8),        1'b0, 5'd0,  64'h0,
              bx(64'h11, 64'h8, 64'h22, 8'h13, 5'd21, MW)};
    vt[4] = '{mk(8'h2F, 5'd0,  5'd2, 5'd1, 1'b0, 32'h7FFFFFFF), 1'b0, 5'd0,  64'h0,
              bx(64'h22, 64'h7FFFFFFF, 64'h11, 8'h2F, 5'd0, BR)};
    vt[5] = '{mk(8'h00, 5'd11, 5'd4, 5'd1, 1'b1, 32'h80000000), 1'b0, 5'd0,  64'h0,
              bx(64'h44, 64'hFFFFFFFF80000000, 64'h11, 8'h00, 5'd11, RW | SF)};
    vt[6] = '{mk(8'h40, 5'd0,  5'd0, 5'd0, 1'b0, 32'h0),        1'b0, 5'd0,  64'h0,
              bx(64'h0, 64'h0, 64'h0, 8'h40, 5'd0, RW | SF)};
    vt[7] = '{mk(8'h40, 5'd13, 5'd12, 5'd1, 1'b0, 32'h0),       1'b1, 5'd12, 64'h1234,
              bx(64'h1234, 64'h11, 64'h11, 8'h40, 5'd13, RW | SF)};

    rst = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b1; flush = 1'b0;
    wb_regwrite = 1'b0; wb_addr = '0; wb_data = '0; wb_setflags = 1'b0; wb_flags = '0;
    cur_exp = '0;

    // Reset state
    tick();
    check64("ready_in_reset", 64'(last_ready), 64'd0);
    tick();
    rst = 1'b0;
    check64("reset_out_valid", 64'(out_valid), 64'd0);
    check64("reset_operand_a", operand_a, 64'd0);
    check64("reset_flags", 64'(flags), 64'd0);
    check64("reset_regwrite", 64'(regwrite), 64'd0);

    // ALU-imm with negative immediate from a fresh reset
    issue(mk(8'h01, 5'd3, 5'd0, 5'd0, 1'b0, 32'hFFFFFFFB),
          bx(64'h0, 64'hFFFFFFFFFFFFFFFB, 64'h0, 8'h01, 5'd3, RW | SF), n);
    check64("first_latency", 64'(n), 64'd1);

    // Preload r1, r2, r4 through writeback
    wb_regwrite = 1'b1;
    wb_addr = 5'd1; wb_data = 64'h11; tick();
    wb_addr = 5'd2; wb_data = 64'h22; tick();
    wb_addr = 5'd4; wb_data = 64'h44; tick();
    wb_regwrite = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wb_regwrite = vt[i].wb_en;
      wb_addr     = vt[i].wb_addr;
      wb_data     = vt[i].wb_data;
      issue(vt[i].instr, vt[i].exp, n);
      wb_regwrite = 1'b0;
    end
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check64("queue_drain", 64'(q.size()), 64'd0);

    // RAW hazard on a load destination released by writeback
    issue(mk(8'h02, 5'd5, 5'd0, 5'd0, 1'b0, 32'h0), bx(64'h0, 64'h0, 64'h0, 8'h02, 5'd5, RW | MR), n);
    in_valid = 1'b1; instruction = mk(8'h00, 5'd6, 5'd5, 5'd0, 1'b0, 32'h0);
    cur_exp = bx(64'h42, 64'h0, 64'h0, 8'h00, 5'd6, RW | SF);
    tick(); check64("raw_stall1", 64'(last_ready), 64'd0);
    tick(); check64("raw_stall2", 64'(last_ready), 64'd0);
    wb_regwrite = 1'b1; wb_addr = 5'd5; wb_data = 64'h42;
    tick(); check64("raw_release", 64'(last_accept), 64'd1);
    wb_regwrite = 1'b0; in_valid = 1'b0;

    // Back-pressure holds the bundle and blocks the next instruction
    issue(mk(8'h01, 5'd14, 5'd1, 5'd0, 1'b0, 32'h7), bx(64'h11, 64'h7, 64'h0, 8'h01, 5'd14, RW | SF), n);
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = mk(8'h01, 5'd15, 5'd2, 5'd0, 1'b0, 32'h1);
    cur_exp = bx(64'h22, 64'h1, 64'h0, 8'h01, 5'd15, RW | SF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check64("bp_ready", 64'(last_ready), 64'd0);
      check64("bp_hold_a", operand_a, 64'h11);
      check64("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick(); check64("bp_accept", 64'(last_accept), 64'd1);
    in_valid = 1'b0;
    tick();

    // r0 writes ignored and never scoreboarded
    wb_regwrite = 1'b1; wb_addr = 5'd0; wb_data = 64'h99; tick(); wb_regwrite = 1'b0;
    issue(mk(8'h01, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1), bx(64'h0, 64'h1, 64'h0, 8'h01, 5'd0, RW | SF), n);
    issue(mk(8'h00, 5'd16, 5'd0, 5'd0, 1'b0, 32'h0), bx(64'h0, 64'h0, 64'h0, 8'h00, 5'd16, RW | SF), n);
    check64("r0_no_pend", 64'(n), 64'd1);

    // Flush squashes the bundle, clears the scoreboard, keeps the writeback
    issue(mk(8'h02, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0), bx(64'h0, 64'h0, 64'h0, 8'h02, 5'd7, RW | MR), n);
    out_ready = 1'b0; flush = 1'b1;
    wb_regwrite = 1'b1; wb_addr = 5'd18; wb_data = 64'h55;
    tick();
    check64("ready_in_flush", 64'(last_ready), 64'd0);
    flush = 1'b0; wb_regwrite = 1'b0; out_ready = 1'b1;
    void'(q.pop_back());
    check64("flush_valid", 64'(out_valid), 64'd0);
    issue(mk(8'h00, 5'd17, 5'd7, 5'd18, 1'b0, 32'h0), bx(64'h0, 64'h55, 64'h55, 8'h00, 5'd17, RW | SF), n);
    check64("flush_sb_clear", 64'(n), 64'd1);

    // Flags update, then reset in the middle of a stall
    wb_setflags = 1'b1; wb_flags = 4'b1010; tick(); wb_setflags = 1'b0;
    check64("flags_set", 64'(flags), 64'hA);
    out_ready = 1'b0;
    issue(mk(8'h01, 5'd19, 5'd1, 5'd0, 1'b0, 32'h2), bx(64'h11, 64'h2, 64'h0, 8'h01, 5'd19, RW | SF), n);
    tick();
    rst = 1'b1; in_valid = 1'b1; instruction = mk(8'h01, 5'd22, 5'd1, 5'd0, 1'b0, 32'h3);
    tick();
    check64("ready_in_rst_stall", 64'(last_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    void'(q.pop_back());
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_flags", 64'(flags), 64'd0);
    check64("rst_operand_a", operand_a, 64'd0);
    check64("rst_regwrite", 64'(regwrite), 64'd0);
    out_ready = 1'b1;
    issue(mk(8'h00, 5'd20, 5'd1, 5'd2, 1'b0, 32'h0), bx(64'h0, 64'h0, 64'h0, 8'h00, 5'd20, RW | SF), n);
    tick();
    check64("final_queue", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
